seq_div16_8: RTL

- Sequential restoring divider, the inverse companion of the 8x8 shift-add multiplier datapath.
- Takes a 16-bit dividend, such as a product held in the 16-bit result register, and an 8-bit divisor.
- Returns a 16-bit quotient and an 8-bit remainder, one quotient bit per enabled clock.
- Used to check products and to recover operands; it handshakes with the top-level control through start/busy/done.

---
 rtl/seq_div16_8_if.sv | 29 ++
 rtl/seq_div16_8.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seq_div16_8_if.sv
// Operand/result bundle for the 16/8 sequential divider.
// Handshake: the controller raises start with valid dividend/divisor while the
// divider is idle; the divider accepts on that enabled edge, holds busy high
// while iterating, and raises done for exactly one enabled cycle once the
// quotient/remainder/div_zero outputs are valid. Start is ignored unless idle.
interface seq_div16_8_if #(
   parameter int DW = 16,
   parameter int VW = 8
);
   logic          clk_ena;
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic          div_zero;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;

   modport master (
      output clk_ena, start, dividend, divisor,
      input  busy, done, div_zero, quotient, remainder
   );

   modport slave (
      input  clk_ena, start, dividend, divisor,
      output busy, done, div_zero, quotient, remainder
   );
endinterface

// File: rtl/seq_div16_8.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one
// quotient bit per enabled clock. Divide-by-zero completes immediately with
// an all-ones quotient and the low dividend bits as remainder.
module seq_div16_8 #(
   parameter int DW = 16,
   parameter int VW = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   seq_div16_8_if.slave          bus,
   output logic [1:0]            dbg_state_o,
   output logic [$clog2(DW)-1:0] dbg_count_o,
   output logic [VW:0]           dbg_partial_o
);
   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [VW:0]   partial_q, partial_d;
   logic [DW-1:0] shift_q, shift_d;
   logic [CW-1:0] count_q, count_d;
   logic [VW-1:0] divisor_q, divisor_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          div_zero_q, div_zero_d;
   logic [DW-1:0] quotient_q, quotient_d;
   logic [VW-1:0] remainder_q, remainder_d;

   // One restoring step: shift in the next dividend bit, trial-subtract.
   logic [VW:0]   p;
   logic          ge;
   logic [VW:0]   partial_nx;
   logic [DW-1:0] shift_nx;

   // Restoring-division datapath for the current iteration.
   always_comb begin
      p          = {partial_q[VW-1:0], shift_q[DW-1]};
      ge         = (p >= {1'b0, divisor_q});
      partial_nx = ge ? (p - {1'b0, divisor_q}) : p;
      shift_nx   = {shift_q[DW-2:0], ge};
   end

   // Next-state and output logic; everything holds while clk_ena is low.
   always_comb begin
      state_d     = state_q;
      partial_d   = partial_q;
      shift_d     = shift_q;
      count_d     = count_q;
      divisor_d   = divisor_q;
      busy_d      = busy_q;
      done_d      = done_q;
      div_zero_d  = div_zero_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      if (bus.clk_ena) begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.divisor != '0) begin
                     shift_d    = bus.dividend;
                     partial_d  = '0;
                     count_d    = '0;
                     divisor_d  = bus.divisor;
                     busy_d     = 1'b1;
                     done_d     = 1'b0;
                     div_zero_d = 1'b0;
                     state_d    = S_CALC;
                  end else begin
                     quotient_d  = '1;
                     remainder_d = bus.dividend[VW-1:0];
                     div_zero_d  = 1'b1;
                     done_d      = 1'b1;
                     state_d     = S_DONE;
                  end
               end
            end
            S_CALC: begin
               shift_d   = shift_nx;
               partial_d = partial_nx;
               count_d   = count_q + CW'(1);
               if (count_q == CW'(DW - 1)) begin
                  quotient_d  = shift_nx;
                  remainder_d = partial_nx[VW-1:0];
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  state_d     = S_DONE;
               end
            end
            S_DONE: begin
               done_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State register with asynchronous abort on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         partial_q   <= '0;
         shift_q     <= '0;
         count_q     <= '0;
         divisor_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         partial_q   <= partial_d;
         shift_q     <= shift_d;
         count_q     <= count_d;
         divisor_q   <= divisor_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         div_zero_q  <= div_zero_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;

   assign dbg_state_o   = state_q;
   assign dbg_count_o   = count_q;
   assign dbg_partial_o = partial_q;
endmodule
